// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte/half/word load-store initiator for a word-wide RAM, sub-word stores via read-modify-write.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE} state_t;
`endif
    state_t            r_state;
    logic [ADDR_W-1:0] r_widx;
    logic [1:0]        r_off;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_buf;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic [1:0]        w_off;
    logic [DATA_W-1:0] w_sh;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_merge;
    logic              w_mis;
    logic              w_unused;

    // Alignment is forced here; the trap path rejects misaligned requests before they use it.
    assign w_off   = req_size == 2'b00 ? req_addr[1:0] : req_size == 2'b01 ? {req_addr[1], 1'b0} : 2'b00;
    assign w_mis   = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
    assign w_sh    = mem_rdata_i >> {r_off, 3'b000};
    assign w_load  = r_size == 2'b00 ? {{24{~r_unsigned & w_sh[7]}}, w_sh[7:0]} :
                     r_size == 2'b01 ? {{16{~r_unsigned & w_sh[15]}}, w_sh[15:0]} : mem_rdata_i;
    assign w_mask  = (r_size[0] ? DATA_W'(32'h0000_FFFF) : DATA_W'(32'h0000_00FF)) << {r_off, 3'b000};
    assign w_merge = r_size[1] ? r_wdata : (r_buf & ~w_mask) | ((r_wdata << {r_off, 3'b000}) & w_mask);
    assign w_unused = ^{req_addr[31:ADDR_W+2], w_mis};

    assign req_ready   = r_state == IDLE;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_err    = r_resp_err;
`else
    assign resp_err    = 1'b0;
`endif
    assign mem_raddr_o = (r_state == LOAD || r_state == RMW_RD) ? r_widx : '0;
    assign mem_waddr_o = r_state == WRITE ? r_widx : '0;
    assign mem_wdata_o = r_state == WRITE ? w_merge : '0;
    // Gated by rst_n so a reset landing on the WRITE edge never commits the store.
    assign mem_we_o    = (r_state == WRITE) & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_widx       <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_wdata      <= '0;
            r_buf        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                IDLE: if (req_valid) begin
                    r_widx     <= req_addr[ADDR_W+1:2];
                    r_off      <= w_off;
                    r_size     <= req_size;
                    r_unsigned <= req_unsigned;
                    r_wdata    <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    r_state    <= w_mis ? ERR : !req_we ? LOAD : req_size[1] ? WRITE : RMW_RD;
`else
                    r_state    <= !req_we ? LOAD : req_size[1] ? WRITE : RMW_RD;
`endif
                end
                LOAD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load;
                    r_state      <= IDLE;
                end
                RMW_RD: begin
                    r_buf   <= mem_rdata_i;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                    r_state      <= IDLE;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                ERR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                    r_resp_rdata <= '0;
                    r_state      <= IDLE;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: table-driven scoreboard bench for lsu_mem_ctrl with a behavioural 128-word RAM.
module tb_lsu_mem_ctrl;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_wdata, mem_rdata;
    logic [6:0]  mem_waddr, mem_raddr;
    logic [31:0] ram [128];
    int n_vec = 0, n_bad = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwe;
        logic [6:0]  waddr;
    } vec_t;
    vec_t vt [19];
    vec_t sb [$];

    lsu_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wdata_o(mem_wdata), .mem_waddr_o(mem_waddr), .mem_we_o(mem_we),
        .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = ram[mem_raddr];
    always @(posedge clk) if (mem_we) ram[mem_waddr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input int idx);
        vec_t v, e;
        int cyc, we_cnt, w;
        logic [6:0] wa;
        v = vt[idx];
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("ready[%0d]", idx), {31'b0, req_ready}, 32'd1);
        req_we = v.we; req_addr = v.addr; req_size = v.size; req_unsigned = v.uns; req_wdata = v.wdata;
        req_valid = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0; we_cnt = 0; wa = '0;
        do begin
            @(negedge clk);
            cyc++;
            if (mem_we) begin
                we_cnt++;
                wa = mem_waddr;
            end
        end while (!resp_valid && cyc < 10);
        e = sb.pop_front();
        chk($sformatf("lat[%0d]", idx), cyc, e.lat);
        chk($sformatf("rdata[%0d]", idx), resp_rdata, e.rdata);
        chk($sformatf("err[%0d]", idx), {31'b0, resp_err}, {31'b0, e.err});
        chk($sformatf("nwe[%0d]", idx), we_cnt, e.nwe);
        if (e.nwe > 0) chk($sformatf("waddr[%0d]", idx), {25'b0, wa}, {25'b0, e.waddr});
    endtask

    initial begin
        int k;
        for (int i = 0; i < 128; i++) ram[i] = '0;
        //          we    addr   sz  uns wdata          rdata                         err   lat          nwe      waddr
        vt[0]  = '{1'b1, 32'h10, 2, 0, 32'h12345678, 32'h0,                        1'b0, 2,            1,       7'd4};
        vt[1]  = '{1'b0, 32'h10, 2, 0, 32'h0,        32'h12345678,                 1'b0, 2,            0,       7'd0};
        vt[2]  = '{1'b1, 32'h12, 1, 0, 32'hDEAD8001, 32'h0,                        1'b0, 3,            1,       7'd4};
        vt[3]  = '{1'b0, 32'h10, 2, 0, 32'h0,        32'h80015678,                 1'b0, 2,            0,       7'd0};
        vt[4]  = '{1'b0, 32'h12, 1, 0, 32'h0,        32'hFFFF8001,                 1'b0, 2,            0,       7'd0};
        vt[5]  = '{1'b0, 32'h12, 1, 1, 32'h0,        32'h00008001,                 1'b0, 2,            0,       7'd0};
        vt[6]  = '{1'b1, 32'h13, 0, 0, 32'h123456AB, 32'h0,                        1'b0, 3,            1,       7'd4};
        vt[7]  = '{1'b0, 32'h13, 0, 0, 32'h0,        32'hFFFFFFAB,                 1'b0, 2,            0,       7'd0};
        vt[8]  = '{1'b0, 32'h13, 0, 1, 32'h0,        32'h000000AB,                 1'b0, 2,            0,       7'd0};
        vt[9]  = '{1'b0, 32'h11, 0, 0, 32'h0,        32'h00000056,                 1'b0, 2,            0,       7'd0};
        vt[10] = '{1'b0, 32'h10, 2, 0, 32'h0,        32'hAB015678,                 1'b0, 2,            0,       7'd0};
        vt[11] = '{1'b1, 32'h200,2, 0, 32'hCAFEF00D, 32'h0,                        1'b0, 2,            1,       7'd0};
        vt[12] = '{1'b0, 32'h0,  2, 0, 32'h0,        32'hCAFEF00D,                 1'b0, 2,            0,       7'd0};
        vt[13] = '{1'b0, 32'h11, 1, 0, 32'h0,        TRAP ? 32'h0 : 32'h00005678,  TRAP, 2,            0,       7'd0};
        vt[14] = '{1'b0, 32'h13, 2, 0, 32'h0,        TRAP ? 32'h0 : 32'hAB015678,  TRAP, 2,            0,       7'd0};
        vt[15] = '{1'b0, 32'h10, 3, 0, 32'h0,        32'hAB015678,                 1'b0, 2,            0,       7'd0};
        vt[16] = '{1'b1, 32'h0,  0, 0, 32'hFFFFFF7F, 32'h0,                        1'b0, 3,            1,       7'd0};
        vt[17] = '{1'b0, 32'h2,  1, 0, 32'h0,        32'hFFFFCAFE,                 1'b0, 2,            0,       7'd0};
        vt[18] = '{1'b0, 32'h0,  2, 1, 32'h0,        32'hCAFEF07F,                 1'b0, 2,            0,       7'd0};

        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {18'b0, mem_waddr, mem_raddr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 19; i++) run_req(i);

        // Reset landing on the WRITE cycle of a byte store must drop the store.
        req_we = 1'b1; req_addr = 32'h13; req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h11;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_before_rst", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1 chk("abort_we", {31'b0, mem_we}, 32'd0);
        k = 0;
        @(negedge clk);
        if (resp_valid) k++;
        rst_n = 1'b1;
        @(negedge clk);
        if (resp_valid) k++;
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        if (resp_valid) k++;
        chk("abort_no_resp", k, 0);
        chk("abort_ram", ram[4], 32'hAB015678);
        vt[0] = '{1'b0, 32'h10, 2, 0, 32'h0, 32'hAB015678, 1'b0, 2, 0, 7'd0};
        run_req(0);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
